// File: rtl/polar_dec_hard.sv
// Hard-decision polar decoder: in-place inverse transform (one butterfly stage per cycle)
// followed by a one-position-per-cycle info-bit scan. Define POLAR_DEC_FROZEN_CHK_EN for frozen checking.

`ifndef CODE_LEN
`define CODE_LEN 1024
`endif
`ifndef POLAR_INFO_MASK_R14
`define POLAR_INFO_MASK_R14 {{256{1'b1}}, {(`CODE_LEN-256){1'b0}}}
`endif
`ifndef POLAR_INFO_MASK_R38
`define POLAR_INFO_MASK_R38 {{384{1'b1}}, {(`CODE_LEN-384){1'b0}}}
`endif

module polar_dec_hard (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 polar_rate_sel,
    input  logic                 polar_dec_start,
    input  logic [`CODE_LEN-1:0] polar_dec_data_in,
    output logic                 polar_dec_busy,
    output logic                 polar_dec_done,
    output logic [383:0]         polar_dec_data_dout,
    output logic                 polar_dec_frozen_err
);
    localparam int N      = `CODE_LEN;
    localparam int NST    = $clog2(N);
    localparam int SW     = $clog2(NST + 1);
    localparam int DOUT_W = 384;
    localparam int WP_W   = $clog2(DOUT_W + 1);
    localparam logic [N-1:0] MASK14 = `POLAR_INFO_MASK_R14;
    localparam logic [N-1:0] MASK38 = `POLAR_INFO_MASK_R38;

    typedef enum logic [1:0] {IDLE, XFORM, SCAN, DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [N-1:0]            r_x;
    logic                    r_rate;
    logic [SW-1:0]           r_stage;
    logic [NST-1:0]          r_j;
    logic [WP_W-1:0]         r_wptr;
    logic [DOUT_W-1:0]       r_dout;
    logic [NST-1:0][N-1:0]   w_st;
    logic [N-1:0]            w_x_bfly;
    logic                    w_info;
    logic                    w_wr_ok;
    logic                    w_accept;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        polar_dec_busy = 1'b0;
        polar_dec_done = 1'b0;
        case (r_state)
            IDLE:  if (polar_dec_start) w_next = XFORM;
            XFORM: begin
                polar_dec_busy = 1'b1;
                if (r_stage == SW'(NST - 1)) w_next = SCAN;
            end
            SCAN: begin
                polar_dec_busy = 1'b1;
                if (r_j == {NST{1'b1}}) w_next = DONE;
            end
            DONE: begin
                polar_dec_done = 1'b1;
                w_next         = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Every stage's butterfly result is built in parallel; the stage counter picks one.
    for (genvar s = 0; s < NST; s++) begin : g_stage
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (((i >> s) & 1) == 0) begin : g_top
                assign w_st[s][i] = r_x[i] ^ r_x[i + 2**s];
            end else begin : g_pass
                assign w_st[s][i] = r_x[i];
            end
        end
    end

    assign w_x_bfly = w_st[r_stage];
    assign w_info   = r_rate ? MASK38[r_j] : MASK14[r_j];
    assign w_wr_ok  = r_wptr < (r_rate ? WP_W'(DOUT_W) : WP_W'(256));
    assign w_accept = (r_state == IDLE) && polar_dec_start;

    // During SCAN x shifts right so x[0] always holds u[j].
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_rate  <= 1'b0;
            r_stage <= '0;
            r_j     <= '0;
            r_wptr  <= '0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (polar_dec_start) begin
                        r_x     <= polar_dec_data_in;
                        r_rate  <= polar_rate_sel;
                        r_stage <= '0;
                        r_j     <= '0;
                        r_wptr  <= '0;
                        r_dout  <= '0;
                    end
                end
                XFORM: begin
                    r_x     <= w_x_bfly;
                    r_stage <= r_stage + 1'b1;
                end
                SCAN: begin
                    r_x <= {1'b0, r_x[N-1:1]};
                    r_j <= r_j + 1'b1;
                    if (w_info && w_wr_ok) begin
                        r_dout[r_wptr] <= r_x[0];
                        r_wptr         <= r_wptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign polar_dec_data_dout = r_dout;

`ifdef POLAR_DEC_FROZEN_CHK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst)                                    r_err <= 1'b0;
        else if (w_accept)                          r_err <= 1'b0;
        else if (r_state == SCAN && !w_info && r_x[0]) r_err <= 1'b1;
    end

    assign polar_dec_frozen_err = r_err;
`else
    assign polar_dec_frozen_err = 1'b0;
`endif

endmodule
